// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit for the HI/LO pair: radix-2 shift-add multiply,
// restoring divide, one iteration per clock, sign correction in a final step.
//
// state | meaning
// IDLE  | waiting for a start request
// RUN   | one shift-add / shift-subtract iteration per cycle, counter walks down
// FIX   | sign correction, result written to hi/lo on exit
// DONE  | one-cycle completion pulse; a new start may be accepted here
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [1:0]           op_q, op_d;
   logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic                 dbz_q, dbz_d;

   logic [WIDTH-1:0]     mag_a, mag_b, quo_fix, rem_fix, a_orig;
   logic [WIDTH:0]       mult_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0]   prod_fix;
   logic                 accept, negate_q;

   assign mag_a = (op[0] && a[WIDTH-1]) ? -a : a;
   assign mag_b = (op[0] && b[WIDTH-1]) ? -b : b;

   // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
   assign mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd_q};

   assign negate_q = op_q[0] && (sign_a_q ^ sign_b_q);
   assign prod_fix = negate_q ? -acc_q : acc_q;
   assign quo_fix  = negate_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = (op_q[0] && sign_a_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   // On the first RUN cycle the low half still holds the dividend magnitude
   assign a_orig   = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

   assign accept = start && !flush && (state_q == S_IDLE || state_q == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dbz_q    <= dbz_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dbz_d    = dbz_q;

      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               state_d = S_IDLE;
               if (accept) begin
                  state_d  = S_RUN;
                  cnt_d    = CNT_INIT;
                  op_d     = op;
                  sign_a_d = op[0] && a[WIDTH-1];
                  sign_b_d = op[0] && b[WIDTH-1];
                  opnd_d   = op[1] ? mag_b : mag_a;
                  acc_d    = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
               end
            end
            S_RUN: begin
               if (op_q[1] && (opnd_q == '0)) begin
                  state_d = S_DONE;
                  hi_d    = a_orig;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
               end else begin
                  if (op_q[1]) begin
                     if (div_diff[WIDTH])
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                     else
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_d = {mult_sum, acc_q[WIDTH-1:1]};
                  end
                  if (cnt_q == '0)
                     state_d = S_FIX;
                  else
                     cnt_d = cnt_q - CW'(1);
               end
            end
            S_FIX: begin
               state_d = S_DONE;
               if (op_q[1]) begin
                  lo_d  = quo_fix;
                  hi_d  = rem_fix;
                  dbz_d = 1'b0;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign stall       = !reset && (busy || accept);
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed results, latency, flush,
// reset, divide-by-zero and start collisions.
module tb_muldiv_sequencer;
   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         flush;
   logic         busy, stall, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;
   int lat, busy_n, dones;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .flush       (flush),
      .busy        (busy),
      .stall       (stall),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents a request at a negedge; returns just after the edge that samples it.
   task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // k counts edges after the start edge; done seen at k means DONE entered at edge k.
   // A one-cycle stray start (divu 1/1) is injected at k == inj_k.
   task automatic wait_done(input int inj_k, output int lat_o, output int busy_o);
      lat_o  = -1;
      busy_o = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (k == inj_k) begin
            op    = 2'b10;
            a     = 32'd1;
            b     = 32'd1;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (busy) busy_o++;
         if (done) begin
            lat_o = k;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (done) n++;
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      #1 check_eq("stall_in_reset", stall, 1'b0);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_hilo", {hi, lo}, 64'h0);
      check_eq("rst_dbz", div_by_zero, 1'b0);

      // multu 7*6 with request-cycle stall and full latency/busy accounting
      op = 2'b00; a = 32'd7; b = 32'd6; start = 1'b1;
      #1 check_eq("stall_req", stall, 1'b1);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(-1, lat, busy_n);
      check_eq("multu_lat", lat, 33);
      check_eq("multu_busy", busy_n, 33);
      check_eq("multu_hilo", {hi, lo}, 64'h00000000_0000002A);
      @(negedge clk);
      check_eq("done_one_cycle", done, 1'b0);
      check_eq("idle_busy", busy, 1'b0);

      start_op(2'b01, 32'hFFFFFFFD, 32'd5);
      wait_done(-1, lat, busy_n);
      check_eq("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

      start_op(2'b10, 32'd100, 32'd7);
      wait_done(-1, lat, busy_n);
      check_eq("divu_lat", lat, 33);
      check_eq("divu_lo", lo, 32'd14);
      check_eq("divu_hi", hi, 32'd2);
      check_eq("divu_dbz", div_by_zero, 1'b0);

      start_op(2'b11, 32'hFFFFFFF9, 32'd2);
      wait_done(-1, lat, busy_n);
      check_eq("div_neg_lo", lo, 32'hFFFFFFFD);
      check_eq("div_neg_hi", hi, 32'hFFFFFFFF);

      start_op(2'b11, 32'd7, 32'hFFFFFFFE);
      wait_done(-1, lat, busy_n);
      check_eq("div_negb_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);

      start_op(2'b11, 32'h12345678, 32'd0);
      wait_done(-1, lat, busy_n);
      check_eq("div0_lat", lat, 1);
      check_eq("div0_hilo", {hi, lo}, 64'h12345678_FFFFFFFF);
      check_eq("div0_dbz", div_by_zero, 1'b1);
      @(negedge clk);
      check_eq("div0_done_one_cycle", done, 1'b0);

      start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(-1, lat, busy_n);
      check_eq("multu_max_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
      check_eq("mult_keeps_dbz", div_by_zero, 1'b1);

      start_op(2'b11, 32'h80000000, 32'hFFFFFFFF);
      wait_done(-1, lat, busy_n);
      check_eq("div_min_hilo", {hi, lo}, 64'h00000000_80000000);
      check_eq("div_min_dbz", div_by_zero, 1'b0);

      // preload hi/lo = 0x11/0x22, then flush a multu mid-run
      start_op(2'b10, 32'h00002211, 32'h00000100);
      wait_done(-1, lat, busy_n);
      check_eq("preload_hilo", {hi, lo}, 64'h00000011_00000022);
      start_op(2'b00, 32'd7, 32'd6);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq("flush_busy", busy, 1'b0);
      check_eq("flush_done", done, 1'b0);
      check_eq("flush_hilo", {hi, lo}, 64'h00000011_00000022);
      count_dones(40, dones);
      check_eq("flush_no_done", dones, 0);

      // flush beats start in the same cycle
      @(negedge clk);
      op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
      #1 check_eq("flush_start_stall", stall, 1'b0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check_eq("flush_start_busy", busy, 1'b0);

      // back-to-back: start during DONE is accepted
      start_op(2'b00, 32'd3, 32'd4);
      wait_done(-1, lat, busy_n);
      check_eq("b2b_first_lo", lo, 32'd12);
      op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
      #1 check_eq("b2b_stall", stall, 1'b1);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(-1, lat, busy_n);
      check_eq("b2b_second_lat", lat, 33);
      check_eq("b2b_second_lo", lo, 32'd25);

      // start during RUN is ignored
      start_op(2'b00, 32'd7, 32'd6);
      wait_done(5, lat, busy_n);
      check_eq("run_start_lat", lat, 33);
      check_eq("run_start_hilo", {hi, lo}, 64'h00000000_0000002A);
      count_dones(40, dones);
      check_eq("run_start_no_extra_done", dones, 0);

      // reset mid-divu with the sticky flag set
      start_op(2'b11, 32'h00000005, 32'd0);
      wait_done(-1, lat, busy_n);
      check_eq("div0b_dbz", div_by_zero, 1'b1);
      start_op(2'b10, 32'd100, 32'd7);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      #1 check_eq("reset_stall", stall, 1'b0);
      @(negedge clk);
      start = 1'b0;
      check_eq("reset_busy", busy, 1'b0);
      check_eq("reset_done", done, 1'b0);
      check_eq("reset_hilo", {hi, lo}, 64'h0);
      check_eq("reset_dbz", div_by_zero, 1'b0);
      reset = 1'b0;
      count_dones(40, dones);
      check_eq("reset_no_done", dones, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request from decode to begin an operation.
REQ-005 The block SHALL have port op, input, 2, where 00=multu, 01=mult, 10=divu and 11=div.
REQ-006 The block SHALL have port a, input, WIDTH, the rs operand (multiplicand or dividend).
REQ-007 The block SHALL have port b, input, WIDTH, the rt operand (multiplier or divisor).
REQ-008 The block SHALL have port flush, input, 1, which aborts the operation in flight (branch or jump squash).
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in RUN or FIX.
REQ-010 The block SHALL have port stall, output, 1, a combinational pipeline freeze request.
REQ-011 The block SHALL have port done, output, 1, a registered one-cycle completion pulse.
REQ-012 The block SHALL have port hi, output, WIDTH, the HI register.
REQ-013 The block SHALL have port lo, output, WIDTH, the LO register.
REQ-014 The block SHALL have port div_by_zero, output, 1, a sticky flag set by the last completed divide.

Function
REQ-015 The block SHALL implement the states IDLE, RUN, FIX and DONE.
REQ-016 When start=1 and flush=0 in IDLE or DONE, the block SHALL latch a, b and op and go to RUN with the iteration counter set to WIDTH-1.
REQ-017 For signed ops the block SHALL latch the operand magnitudes and record sign_a and sign_b.
REQ-018 When start=1 arrives in RUN or FIX, the block SHALL ignore it.
REQ-019 In RUN the block SHALL perform one iteration per cycle:
  - multiply: radix-2 shift-add into a 2*WIDTH accumulator;
  - divide: one restoring shift-subtract step.
REQ-020 After the counter reaches 0 in RUN, the block SHALL go to FIX.
REQ-021 In FIX the block SHALL apply sign correction:
  - product negated if sign_a^sign_b (signed mult);
  - quotient negated if sign_a^sign_b and remainder negated if sign_a (signed div).
REQ-022 The block SHALL write the result to hi/lo at the FIX->DONE edge:
  - multiply: hi=upper half, lo=lower half;
  - divide: lo=quotient, hi=remainder.
REQ-023 Latency: for start sampled at edge N, hi/lo SHALL be valid and done=1 in the cycle after edge N+WIDTH+1 (done at cycle N+WIDTH+2 for WIDTH=32, counting the start edge as cycle 0).
REQ-024 done SHALL be high only in DONE, which lasts exactly one cycle, then the block SHALL return to IDLE unless a new start is accepted.
REQ-025 stall SHALL equal busy OR (start AND NOT flush AND state is IDLE or DONE), so decode freezes from the request cycle onward.
REQ-026 A divide with b==0 SHALL skip RUN and FIX and go straight to DONE on the next edge with hi=a (unmodified), lo=all ones and div_by_zero=1.
REQ-027 Every other completed divide SHALL clear div_by_zero; multiplies SHALL leave it unchanged.
REQ-028 Signed div of -2^(WIDTH-1) by -1 SHALL give lo=0x80000000 and hi=0 with no flag.
REQ-029 When flush=1 in any state, the block SHALL go to IDLE on the next edge with no done pulse and hi, lo and div_by_zero unchanged; flush and start in the same cycle SHALL give flush priority.
REQ-030 hi and lo SHALL change only at DONE entry or reset.

Reset
REQ-031 While reset=1, from any state, the block SHALL go to IDLE and clear hi, lo, busy, done, div_by_zero and the counter.
REQ-032 Reset mid-operation SHALL produce no done pulse; reset SHALL take priority over start and flush.
REQ-033 stall SHALL be 0 while reset=1.

Verification
REQ-034 multu a=7, b=6 -> busy for 33 cycles, done at cycle 34, hi=0x00000000, lo=0x0000002A.
REQ-035 mult a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-036 Signed divide:
  - divu a=100, b=7 -> lo=14, hi=2, div_by_zero=0;
  - div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 div a=0x12345678, b=0 -> done 2 cycles after start, hi=0x12345678, lo=0xFFFFFFFF, div_by_zero=1.
REQ-038 Flush and reset mid-operation:
  - multu started with hi/lo=0x11/0x22 preloaded, flush at cycle 10 -> IDLE, no done, hi/lo still 0x11/0x22, busy=0 next cycle;
  - reset at cycle 20 of a divu -> all outputs 0, no done.
REQ-039 Back-to-back and collision handling:
  - start asserted during DONE -> second operation accepted, done again 34 cycles later;
  - start asserted during RUN -> ignored.
